risc16_dmem_resp: RTL

RISC16_DMEM_RESP -- requirements
Module: risc16_dmem_resp

---
 rtl/risc16_dmem_resp.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/risc16_dmem_resp.sv
// RISC16 data-memory responder: word RAM, console output FIFO, STATUS/CYCLE MMIO registers.
// Define RISC16_DMEM_CYCLE_COUNTER_EN to build the free-running counter readable at CYCLE.
module risc16_dmem_resp #(
    parameter int MEM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe,
    output logic [15:0] ddin,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [14:0] CONSOLE_W = 15'h7F80;
    localparam logic [14:0] STATUS_W  = 15'h7F81;
    localparam logic [14:0] CYCLE_W   = 15'h7F82;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Address decode; daddr[0] never selects anything.
    logic          addr_lsb_unused;
    logic [AW-1:0] word_idx;
    logic          ram_hit;
    logic          con_hit;
    logic          status_hit;
    logic          cycle_hit;

    assign addr_lsb_unused = daddr[0];
    assign word_idx        = daddr[AW:1];
    assign ram_hit         = (daddr[15:AW+1] == '0);
    assign con_hit         = (daddr[15:1] == CONSOLE_W);
    assign status_hit      = (daddr[15:1] == STATUS_W);
    assign cycle_hit       = (daddr[15:1] == CYCLE_W);

    // RAM: asynchronous read, synchronous write.
    logic [15:0] mem [MEM_WORDS];

    // NOTE: RAM has no reset branch; a reset would turn the array into flops and
    // prevent RAM inference, and software never relies on initial contents.
    always_ff @(posedge clk) begin
        if (dwe && ram_hit) begin
            mem[word_idx] <= ddout;
        end
    end

    // Console FIFO state.
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          con_valid_q, con_valid_d;
    logic          overflow_q, overflow_d;

    logic fifo_empty;
    logic fifo_full;
    logic con_wr;
    logic status_wr;
    logic pop;
    logic push;
    logic ovf_event;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign con_wr     = dwe & con_hit;
    assign status_wr  = dwe & status_hit;
    assign pop        = con_valid_q & con_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push       = con_wr & (~fifo_full | pop);
    assign ovf_event  = con_wr & fifo_full & ~pop;

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned
        // and no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (status_wr) begin
            overflow_d = 1'b0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end

        con_valid_d = (count_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            con_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            con_valid_q <= con_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_q] <= ddout[7:0];
        end
    end

    assign con_valid = con_valid_q;
    assign con_data  = con_valid_q ? fifo_mem[rd_ptr_q] : 8'h00;

    // Cycle counter (optional).
    logic [15:0] cycle_rd;

`ifdef RISC16_DMEM_CYCLE_COUNTER_EN
    logic [15:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = 16'h0000;
`endif

    // Zero-latency read mux; CONSOLE and unmapped addresses read as zero.
    always_comb begin
        ddin = 16'h0000;
        if (doe) begin
            if (ram_hit) begin
                ddin = mem[word_idx];
            end else if (status_hit) begin
                ddin = {13'b0, overflow_q, fifo_full, fifo_empty};
            end else if (cycle_hit) begin
                ddin = cycle_rd;
            end
        end
    end

endmodule
